// File: rtl/tmw_sampler.sv
// Parity sampler for a timed-window TRNG: one parity bit per counted window, packed into
// W-bit words behind a valid/ready buffer, guarded by a repetition-count health test.
module tmw_sampler #(
    parameter int N         = 5,
    parameter int W         = 8,
    parameter int MIN_CNT   = 4,
    parameter int RCT_LIMIT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en_in,
    input  logic [N-1:0] cnt_in,
    input  logic         raw_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         ovf,
    output logic         rct_fail
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);

    localparam logic [N-1:0]     MIN_CNT_N = N'(MIN_CNT);
    localparam logic [RUN_W-1:0] RCT_LIM   = RUN_W'(RCT_LIMIT);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        FAIL   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             parity_q, parity_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             prev_q, prev_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             ovf_q, ovf_d;
    logic             rct_fail_q, rct_fail_d;

    logic             bit_acc;
    logic [RUN_W-1:0] run_next;
    logic [W-1:0]     word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            parity_q    <= 1'b0;
            idx_q       <= '0;
            run_q       <= '0;
            prev_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            rct_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            parity_q    <= parity_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            rct_fail_q  <= rct_fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        parity_d    = parity_q;
        idx_d       = idx_q;
        run_d       = run_q;
        prev_d      = prev_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        rct_fail_d  = rct_fail_q;
        bit_acc     = 1'b0;
        run_next    = run_q;
        word        = acc_q;

        if (clr) begin
            state_d     = IDLE;
            parity_d    = 1'b0;
            idx_d       = '0;
            run_d       = '0;
            prev_d      = 1'b0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            ovf_d       = 1'b0;
            rct_fail_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_in) begin
                        state_d  = WINDOW;
                        parity_d = raw_bit;
                    end
                end
                WINDOW: begin
                    if (en_in) begin
                        parity_d = parity_q ^ raw_bit;
                    end else begin
                        state_d = IDLE;
                        bit_acc = (cnt_in >= MIN_CNT_N);
                    end
                end
                FAIL: begin
                end
                default: state_d = IDLE;
            endcase

            // FAIL freezes everything except clr/rst_n; out_valid is already low there.
            if (state_q != FAIL) begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end

                if (bit_acc) begin
                    // run_q == 0 marks "no accepted bit yet" since the last reset/clear.
                    if ((run_q == '0) || (parity_q != prev_q)) begin
                        run_next = RUN_ONE;
                    end else begin
                        run_next = run_q + RUN_ONE;
                    end
                    run_d  = run_next;
                    prev_d = parity_q;

                    if (run_next == RCT_LIM) begin
                        state_d     = FAIL;
                        rct_fail_d  = 1'b1;
                        acc_d       = '0;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                    end else begin
                        word[idx_q] = parity_q;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            acc_d = '0;
                            if (!out_valid_q || out_ready) begin
                                out_valid_d = 1'b1;
                                out_data_d  = word;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            acc_d = word;
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign rct_fail  = rct_fail_q;

endmodule
